// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry full adder with optional output register
module full_adder #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             out_valid
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = Ci;

  // One classic 1-bit full-adder cell per operand bit, chained LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] q_r;
    logic             co_r;
    logic             valid_r;

    // Capture the sum every cycle; out_valid tells consumers which results count
    always_ff @(posedge clk) begin
      if (rst) begin
        q_r     <= '0;
        co_r    <= 1'b0;
        valid_r <= 1'b0;
      end else begin
        q_r     <= sum;
        co_r    <= carry[WIDTH];
        valid_r <= in_valid;
      end
    end

    assign Q         = q_r;
    assign Co        = co_r;
    assign out_valid = valid_r;
  end else begin : g_comb
    // Clock, reset and qualifier have no role in the combinational build
    logic unused_ok;
    assign unused_ok = ^{clk, rst, in_valid};

    assign Q         = sum;
    assign Co        = carry[WIDTH];
    assign out_valid = 1'b1;
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed and random checks of full_adder in three configurations
`timescale 1ps/1ps
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic no_valid = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #500 clk = ~clk;

  // WIDTH=1, combinational
  logic a1, b1, c1, q1, co1, ov1;
  full_adder #(.WIDTH(1), .REGISTERED(0)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(no_valid),
    .A(a1), .B(b1), .Ci(c1), .Q(q1), .Co(co1), .out_valid(ov1)
  );

  // WIDTH=8, combinational
  logic [7:0] a8, b8, q8;
  logic       c8, co8, ov8;
  full_adder #(.WIDTH(8), .REGISTERED(0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(no_valid),
    .A(a8), .B(b8), .Ci(c8), .Q(q8), .Co(co8), .out_valid(ov8)
  );

  // WIDTH=4, registered
  logic [3:0] a4, b4, q4;
  logic       c4, co4, ov4, iv4;
  full_adder #(.WIDTH(4), .REGISTERED(1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4),
    .A(a4), .B(b4), .Ci(c4), .Q(q4), .Co(co4), .out_valid(ov4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    a4 = a; b4 = b; c4 = c; iv4 = v;
  endtask

  // expected {Q,Co} for {A,B,Ci} = 0..7
  logic [1:0] tt [8];
  logic [8:0] exp9;

  initial begin
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    a1 = 0; b1 = 0; c1 = 0;
    a8 = '0; b8 = '0; c8 = 0;
    drive4(4'h0, 4'h0, 1'b0, 1'b0);

    // 1-bit truth table, one combination per 100 ps
    for (int k = 0; k < 8; k++) begin
      {a1, b1, c1} = 3'(k);
      #100;
      check($sformatf("w1_q_%0d", k), 64'(q1), 64'(tt[k][1]));
      check($sformatf("w1_co_%0d", k), 64'(co1), 64'(tt[k][0]));
      check($sformatf("w1_ov_%0d", k), 64'(ov1), 64'd1);
    end

    // 8-bit directed boundaries
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #100;
    check("w8_ripple", 64'({co8, q8}), 64'(9'h100));
    a8 = 8'h5A; b8 = 8'h25; c8 = 1'b0; #100;
    check("w8_5a_25", 64'({co8, q8}), 64'(9'h07F));
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #100;
    check("w8_all_ones", 64'({co8, q8}), 64'(9'h1FF));
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #100;
    check("w8_zero", 64'({co8, q8}), 64'(9'h000));
    check("w8_ov", 64'(ov8), 64'd1);

    // 8-bit random against the arithmetic definition
    for (int k = 0; k < 1000; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      #100;
      check("w8_rand", 64'({co8, q8}), 64'(exp9));
    end

    // registered: reset held two cycles
    rst = 1'b1;
    drive4(4'h7, 4'h7, 1'b1, 1'b1);
    tick(); tick();
    check("w4_rst", 64'({ov4, co4, q4}), 64'd0);

    // first vector after release: F+1+0
    rst = 1'b0;
    drive4(4'hF, 4'h1, 1'b0, 1'b1);
    tick();
    check("w4_f_1", 64'({ov4, co4, q4}), 64'({1'b1, 1'b1, 4'h0}));

    // back-to-back stream
    drive4(4'h3, 4'h4, 1'b1, 1'b1);
    tick();
    check("w4_bb1", 64'({ov4, co4, q4}), 64'({1'b1, 1'b0, 4'h8}));
    drive4(4'h9, 4'h9, 1'b0, 1'b1);
    tick();
    check("w4_bb2", 64'({ov4, co4, q4}), 64'({1'b1, 1'b1, 4'h2}));
    drive4(4'hF, 4'hF, 1'b1, 1'b1);
    tick();
    check("w4_bb3", 64'({ov4, co4, q4}), 64'({1'b1, 1'b1, 4'hF}));
    drive4(4'h1, 4'h2, 1'b0, 1'b0);
    tick();
    check("w4_idle", 64'({ov4, co4, q4}), 64'({1'b0, 1'b0, 4'h3}));

    // reset mid-stream discards the in-flight result
    drive4(4'h2, 4'h3, 1'b0, 1'b1);
    tick();
    check("w4_pre_rst", 64'({ov4, co4, q4}), 64'({1'b1, 1'b0, 4'h5}));
    rst = 1'b1;
    drive4(4'h1, 4'h1, 1'b0, 1'b1);
    tick();
    check("w4_mid_rst", 64'({ov4, co4, q4}), 64'd0);
    rst = 1'b0;
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    check("w4_no_stale", 64'({ov4, co4, q4}), 64'd0);
    drive4(4'hA, 4'h6, 1'b1, 1'b1);
    tick();
    check("w4_resume", 64'({ov4, co4, q4}), 64'({1'b1, 1'b1, 4'h1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1);
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Binary full-adder block: sums A, B and carry-in Ci, producing sum Q and carry-out Co.
- Generalised to a WIDTH-bit ripple-carry chain of 1-bit full-adder cells.
- Optional output register stage.
- Used as the arithmetic leaf cell for wider adders and counters. The default configuration (WIDTH=1, REGISTERED=0) is the classic combinational 1-bit full adder.

Parameters:
- WIDTH, 1, operand width in bits; number of chained full-adder cells (legal range 1..64).
- REGISTERED, 0, 0 = Q/Co combinational from inputs; 1 = Q/Co/out_valid registered on rising clk (1-cycle latency).

Ports:
- clk  input  1  clock; used only when REGISTERED=1.
- rst  input  1  synchronous active-high reset; used only when REGISTERED=1.
- in_valid  input  1  qualifies A/B/Ci; only meaningful when REGISTERED=1.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Ci  input  1  carry-in into bit 0.
- Q  output  WIDTH  sum bits.
- Co  output  1  carry-out of the MSB cell.
- out_valid  output  1  Q/Co valid; tied 1 when REGISTERED=0.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Cell i (0..WIDTH-1):
  - c[0]=Ci.
  - Q[i] = A[i] XOR B[i] XOR c[i].
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]).
  - Co = c[WIDTH].
- Arithmetic equivalent: {Co,Q} = A + B + Ci, unsigned, WIDTH+1 bits; no truncation, no saturation.
- 1-bit truth table (A B Ci -> Q Co): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
- REGISTERED=0:
  - Purely combinational; outputs settle within the same time step as any input change.
  - No latches, no state.
  - clk, rst and in_valid are ignored.
  - out_valid=1 constantly.
- REGISTERED=1:
  - On each rising clk with rst=0, Q and Co capture the combinational sum of the current inputs, and out_valid captures in_valid.
  - Latency is exactly 1 cycle; a new operand pair is accepted every cycle.
  - Q/Co are updated regardless of in_valid; consumers qualify with out_valid.
- Reset (REGISTERED=1):
  - On a rising clk with rst=1: Q=0, Co=0, out_valid=0.
  - Reset has priority over input capture.
  - Reset mid-stream discards the in-flight result; the first valid result after rst deasserts appears one cycle after its in_valid.
- Boundary conditions:
  - All-ones + all-ones + Ci=1 gives Q=all-ones, Co=1.
  - All-zeros + Ci=0 gives Q=0, Co=0.
  - Carry propagates across all WIDTH cells, e.g. A=all-ones, B=0, Ci=1 gives Q=0, Co=1.
- X/Z on inputs propagates per standard gate semantics; no masking logic.

Test Plan:
- WIDTH=1, REGISTERED=0: step A,B,Ci through 000..111, one combination per 100 ps -> Q,Co match the truth table above at each step (e.g. 011 -> Q=0,Co=1; 111 -> Q=1,Co=1).
- WIDTH=8, REGISTERED=0: A=8'hFF, B=8'h00, Ci=1 -> Q=8'h00, Co=1 (full carry ripple). Then A=8'h5A, B=8'h25, Ci=0 -> Q=8'h7F, Co=0.
- WIDTH=8, REGISTERED=0: 1000 random A/B/Ci -> {Co,Q} == A+B+Ci every vector.
- WIDTH=4, REGISTERED=1: hold rst=1 for 2 cycles -> Q=0, Co=0, out_valid=0. Release, then apply A=4'hF, B=4'h1, Ci=0, in_valid=1 -> next edge Q=4'h0, Co=1, out_valid=1.
- WIDTH=4, REGISTERED=1: back-to-back vectors (3+4+1, 9+9+0, 15+15+1) on consecutive cycles -> results 4'h8/0, 4'h2/1, 4'hF/1 appear one cycle each after their inputs.
- WIDTH=4, REGISTERED=1: assert rst in the cycle following a valid input -> on that edge outputs go 0/0/0 and the pending result is never presented.
